// File: rtl/pc_sequencer.sv
// Program counter with integrated source mux and hardware return-address stack.
// Drives the fetch address; PC_LD/PC_INC steer the PC, PUSH/POP steer the stack.
module pc_sequencer #(
    parameter int                ADDR_W      = 10,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] INTR_VEC    = ADDR_W'(10'h3FF)
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic [ADDR_W-1:0]                FROM_IMMED,
    input  logic [1:0]                       PC_MUX_SEL,
    input  logic                             PC_LD,
    input  logic                             PC_INC,
    input  logic                             PUSH,
    input  logic                             POP,
    input  logic                             ERR_CLR,
    output logic [ADDR_W-1:0]                PC_COUNT,
    output logic [ADDR_W-1:0]                STACK_TOP,
    output logic [$clog2(STACK_DEPTH):0]     STACK_CNT,
    output logic                             STACK_EMPTY,
    output logic                             STACK_FULL,
    output logic                             STACK_ERR
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_plus1;
    logic [PTR_W-1:0]  top_idx;
    logic              empty, full;
    logic [ADDR_W-1:0] stack_top;
    logic              stk_we;
    logic [PTR_W-1:0]  stk_waddr;

    assign pc_plus1  = pc_q + ADDR_W'(1);
    // Index wraps to all-ones when empty; the read is masked by `empty` below.
    assign top_idx   = PTR_W'(cnt_q - CNT_W'(1));
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stack_top = empty ? '0 : mem_q[top_idx];

    // Next PC: load beats increment beats hold; reserved select holds the PC.
    always_comb begin
        pc_d = pc_q;
        if (PC_LD) begin
            case (PC_MUX_SEL)
                2'd0:    pc_d = FROM_IMMED;
                2'd1:    pc_d = stack_top;
                2'd2:    pc_d = INTR_VEC;
                default: pc_d = pc_q;
            endcase
        end else if (PC_INC) begin
            pc_d = pc_plus1;
        end
    end

    // Stack pointer, write port and sticky error; a new error overrides ERR_CLR.
    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        stk_we    = 1'b0;
        stk_waddr = cnt_q[PTR_W-1:0];
        if (ERR_CLR) err_d = 1'b0;
        if (PUSH && POP && !empty) begin
            // Replace the top entry in place: net depth unchanged.
            stk_we    = 1'b1;
            stk_waddr = top_idx;
        end else if (PUSH) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                stk_we = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (POP) begin
            if (empty) err_d = 1'b1;
            else       cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; never read past the count, so no reset needed.
    always_ff @(posedge CLK) begin
        if (stk_we) mem_q[stk_waddr] <= pc_plus1;
    end

    assign PC_COUNT    = pc_q;
    assign STACK_TOP   = stack_top;
    assign STACK_CNT   = cnt_q;
    assign STACK_EMPTY = empty;
    assign STACK_FULL  = full;
    assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;

    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int MASK  = 10'h3FF;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [AW-1:0] FROM_IMMED;
    logic [1:0]    PC_MUX_SEL;
    logic          PC_LD, PC_INC, PUSH, POP, ERR_CLR;
    logic [AW-1:0] PC_COUNT, STACK_TOP;
    logic [3:0]    STACK_CNT;
    logic          STACK_EMPTY, STACK_FULL, STACK_ERR;

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .INTR_VEC(10'h3FF)) dut (
        .CLK(CLK), .RST_N(RST_N), .FROM_IMMED(FROM_IMMED), .PC_MUX_SEL(PC_MUX_SEL),
        .PC_LD(PC_LD), .PC_INC(PC_INC), .PUSH(PUSH), .POP(POP), .ERR_CLR(ERR_CLR),
        .PC_COUNT(PC_COUNT), .STACK_TOP(STACK_TOP), .STACK_CNT(STACK_CNT),
        .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .STACK_ERR(STACK_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_pc  = 0;
    int unsigned m_stk[$];
    bit          m_err = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned top;
        top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
        check({tag, ".pc"},    int'(PC_COUNT),    m_pc);
        check({tag, ".top"},   int'(STACK_TOP),   top);
        check({tag, ".cnt"},   int'(STACK_CNT),   m_stk.size());
        check({tag, ".empty"}, int'(STACK_EMPTY), (m_stk.size() == 0) ? 1 : 0);
        check({tag, ".full"},  int'(STACK_FULL),  (m_stk.size() == DEPTH) ? 1 : 0);
        check({tag, ".err"},   int'(STACK_ERR),   int'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_err = 0;
    endtask

    // One clock: drive at the falling edge, advance the model, check at the next falling edge.
    task automatic cycle(input string tag, input bit ld, input bit inc, input int sel,
                         input int unsigned imm, input bit push, input bit pop, input bit clr);
        int unsigned old_top, ret;
        PC_LD = ld; PC_INC = inc; PC_MUX_SEL = 2'(sel); FROM_IMMED = AW'(imm);
        PUSH = push; POP = pop; ERR_CLR = clr;
        @(posedge CLK);
        old_top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
        ret     = (m_pc + 1) & MASK;
        if (clr) m_err = 0;
        if (push && pop && m_stk.size() != 0)  m_stk[m_stk.size()-1] = ret;
        else if (push) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back(ret);
        end else if (pop) begin
            if (m_stk.size() == 0) m_err = 1;
            else void'(m_stk.pop_back());
        end
        if (ld) begin
            if (sel == 0)      m_pc = imm & MASK;
            else if (sel == 1) m_pc = old_top;
            else if (sel == 2) m_pc = 10'h3FF;
        end else if (inc) m_pc = ret;
        @(negedge CLK);
        check_all(tag);
    endtask

    initial begin
        RST_N = 1'b0; FROM_IMMED = '0; PC_MUX_SEL = '0;
        PC_LD = 0; PC_INC = 0; PUSH = 0; POP = 0; ERR_CLR = 0;
        repeat (2) @(negedge CLK);
        check_all("reset");
        RST_N = 1'b1;

        // Asynchronous reset mid-run
        cycle("ld155", 1, 0, 0, 'h155, 0, 0, 0);
        check("pc155", int'(PC_COUNT), 'h155);
        PC_INC = 1;
        #2 RST_N = 1'b0;
        #1 model_reset();
        check("async_rst_pc", int'(PC_COUNT), 0);
        @(negedge CLK);
        check_all("rst_hold");
        RST_N = 1'b1;
        cycle("inc1", 0, 1, 0, 0, 0, 0, 0);
        check("inc1_lit", int'(PC_COUNT), 1);
        cycle("inc2", 0, 1, 0, 0, 0, 0, 0);
        cycle("inc3", 0, 1, 0, 0, 0, 0, 0);
        check("inc3_lit", int'(PC_COUNT), 3);
        cycle("ld3ff", 1, 0, 0, 'h3FF, 0, 0, 0);
        cycle("wrap", 0, 1, 0, 0, 0, 0, 0);
        check("wrap_lit", int'(PC_COUNT), 0);

        // Load priority and sources
        cycle("ld_pri", 1, 1, 0, 'h0A5, 0, 0, 0);
        check("ld_pri_lit", int'(PC_COUNT), 'h0A5);
        cycle("intr", 1, 1, 2, 'h123, 0, 0, 0);
        check("intr_lit", int'(PC_COUNT), 'h3FF);
        cycle("sel3", 1, 1, 3, 'h123, 0, 0, 0);
        check("sel3_lit", int'(PC_COUNT), 'h3FF);

        // Call / return
        cycle("pc010", 1, 0, 0, 'h010, 0, 0, 0);
        cycle("call1", 1, 0, 0, 'h200, 1, 0, 0);
        check("call1_top", int'(STACK_TOP), 'h011);
        cycle("call2", 1, 0, 0, 'h300, 1, 0, 0);
        check("call2_top", int'(STACK_TOP), 'h201);
        cycle("ret1", 1, 0, 1, 0, 0, 1, 0);
        check("ret1_pc", int'(PC_COUNT), 'h201);
        cycle("ret2", 1, 0, 1, 0, 0, 1, 0);
        check("ret2_pc", int'(PC_COUNT), 'h011);
        check("ret2_empty", int'(STACK_EMPTY), 1);

        // Overflow
        for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, 0, 0, 1, 0, 0);
        check("full_lit", int'(STACK_FULL), 1);
        cycle("ovf", 0, 1, 0, 0, 1, 0, 0);
        check("ovf_cnt", int'(STACK_CNT), 8);
        check("ovf_err", int'(STACK_ERR), 1);
        cycle("ovf_clr", 0, 0, 0, 0, 0, 0, 1);
        check("ovf_clr_err", int'(STACK_ERR), 0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 0, 0, 0, 0, 1, 0);

        // Underflow
        cycle("unf", 0, 0, 0, 0, 0, 1, 0);
        check("unf_err", int'(STACK_ERR), 1);
        cycle("ret_empty", 1, 0, 1, 0, 0, 1, 0);
        check("ret_empty_pc", int'(PC_COUNT), 0);
        cycle("unf_clr", 0, 0, 0, 0, 0, 0, 1);
        cycle("clr_vs_err", 0, 0, 0, 0, 0, 1, 1);
        check("clr_vs_err_lit", int'(STACK_ERR), 1);
        cycle("unf_clr2", 0, 0, 0, 0, 0, 0, 1);

        // Simultaneous push/pop replaces top only
        cycle("pc030", 1, 0, 0, 'h030, 0, 0, 0);
        cycle("pushA", 1, 0, 0, 'h04F, 1, 0, 0);
        cycle("pushB", 1, 0, 0, 'h120, 1, 0, 0);
        check("pushB_top", int'(STACK_TOP), 'h050);
        cycle("swap", 0, 0, 0, 0, 1, 1, 0);
        check("swap_top", int'(STACK_TOP), 'h121);
        check("swap_cnt", int'(STACK_CNT), 2);
        cycle("below", 0, 0, 0, 0, 0, 1, 0);
        check("below_top", int'(STACK_TOP), 'h031);
        cycle("swap_empty_pre", 0, 0, 0, 0, 0, 1, 0);
        cycle("swap_empty", 0, 0, 0, 0, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle("rand", $urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), $urandom & MASK,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-generation program-counter unit. It merges the PC-source mux and the program counter into one block, parametrised in address width. It adds an internal hardware return-address stack for CALL/RET and an interrupt-vector load source. The block sits in the fetch stage, drives the instruction memory address, and is controlled cycle-by-cycle by the control unit.

Parameters:
ADDR_W, 10, width of PC and of every address path.
STACK_DEPTH, 8, number of return-address entries; power of two, minimum 2.
INTR_VEC, 10'h3FF (ADDR_W bits), address loaded when PC_MUX_SEL selects the interrupt source.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST_N  input  1  asynchronous active-low reset.
FROM_IMMED  input  ADDR_W  branch/call target from instruction field.
PC_MUX_SEL  input  2  load source: 0 = FROM_IMMED, 1 = stack top, 2 = INTR_VEC, 3 = reserved (treated as hold).
PC_LD  input  1  load PC from selected source.
PC_INC  input  1  increment PC by 1.
PUSH  input  1  push PC_COUNT+1 onto return stack (CALL / interrupt entry).
POP  input  1  pop return stack (RET / RETI).
ERR_CLR  input  1  synchronous clear of STACK_ERR.
PC_COUNT  output  ADDR_W  current program counter.
STACK_TOP  output  ADDR_W  current top-of-stack entry; 0 when empty.
STACK_CNT  output  clog2(STACK_DEPTH)+1  number of valid entries.
STACK_EMPTY  output  1  STACK_CNT == 0.
STACK_FULL  output  1  STACK_CNT == STACK_DEPTH.
STACK_ERR  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (RST_N low, asynchronous, no clock needed): PC_COUNT=0, STACK_CNT=0, STACK_ERR=0, STACK_EMPTY=1, STACK_FULL=0, STACK_TOP=0. Stack RAM contents need not be cleared. Outputs hold reset values while RST_N is low. First update occurs on the first rising CLK after deassertion.
- PC update, one cycle latency. Priority: PC_LD > PC_INC > hold.
  - PC_LD=1: PC_COUNT <= selected source. For SEL=3, PC holds.
  - Else PC_INC=1: PC_COUNT <= PC_COUNT+1 modulo 2^ADDR_W. Max value wraps to 0.
- Stack source (SEL=1) uses the STACK_TOP value present before the edge. This makes RET (PC_LD, SEL=1, POP in the same cycle) correct in one cycle. SEL=1 on an empty stack loads 0.
- PUSH (POP=0):
  - Not full: entry[CNT] <= PC_COUNT+1 (wrapped, pre-edge PC); CNT increments.
  - Full: no write, CNT unchanged, STACK_ERR <= 1.
- POP (PUSH=0):
  - Not empty: CNT decrements.
  - Empty: CNT stays 0, STACK_ERR <= 1.
- PUSH and POP in the same cycle:
  - Not empty: replace top entry with PC_COUNT+1; CNT unchanged; no error.
  - Empty: behaves as a push.
- PUSH/POP act independently of PC_LD/PC_INC. CALL = PC_LD, SEL=0, PUSH in one cycle: stack gets return address, PC gets target.
- STACK_ERR is sticky until ERR_CLR or reset. If ERR_CLR and a new error occur in the same cycle, the error wins (flag stays 1).
- STACK_TOP, STACK_EMPTY, STACK_FULL, STACK_CNT are registered-state derived (combinational from CNT and stack RAM). They update in the same cycle as the push/pop edge.
- No X propagation: SEL=3 and unused inputs must never corrupt state.

Test Plan:
- Reset/increment: RST_N low mid-run with PC=0x155 -> PC_COUNT=0 immediately (asynchronous). Then PC_INC for 3 cycles -> 1, 2, 3. PC=0x3FF + PC_INC -> 0x000.
- Load priority: PC_LD=1, PC_INC=1, SEL=0, FROM_IMMED=0x0A5 -> PC=0x0A5 next cycle. SEL=2 -> PC=0x3FF. SEL=3 -> PC unchanged.
- Call/return: PC=0x010, CALL to 0x200 (PC_LD, SEL=0, PUSH) -> PC=0x200, STACK_TOP=0x011, CNT=1. Nested CALL at 0x200 to 0x300 -> TOP=0x201, CNT=2. RET (PC_LD, SEL=1, POP) -> PC=0x201, CNT=1. Second RET -> PC=0x011, CNT=0, EMPTY=1.
- Overflow: 8 pushes -> FULL=1, CNT=8. 9th push -> CNT=8, TOP unchanged, STACK_ERR=1. ERR_CLR -> STACK_ERR=0.
- Underflow: POP on empty -> CNT=0, ERR=1. RET on empty -> PC=0. ERR_CLR together with another empty POP -> ERR stays 1.
- Simultaneous push/pop: CNT=2, TOP=0x050, PC=0x120, PUSH+POP -> CNT=2, TOP=0x121, entry below unchanged (verified by a subsequent pop).
